// File: rtl/ibex_pkg.sv
// Minimal subset of the Ibex package: ALU operator and bitmanip configuration enums
// as used by the ALU multicycle controller.
package ibex_pkg;

    typedef enum integer {
        RV32BNone,
        RV32BBalanced,
        RV32BOTEarlGrey,
        RV32BFull
    } rv32b_e;

    typedef enum logic [6:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SRA,
        ALU_SRL,
        ALU_SLL,
        ALU_ROR,
        ALU_ROL,
        ALU_FSL,
        ALU_FSR
    } alu_op_e;

endpackage

// File: rtl/ibex_alu_multicycle_ctrl.sv
// Issue/sequencing controller for ibex_alu: latches one op per handshake, sequences one or two
// execute cycles, owns the intermediate-value registers and holds the result for writeback.
module ibex_alu_multicycle_ctrl
    import ibex_pkg::*;
#(
    parameter rv32b_e RV32B = RV32BNone
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  alu_op_e        operator_i,
    input  logic [31:0]    operand_a_i,
    input  logic [31:0]    operand_b_i,
    input  logic           flush_i,
    output alu_op_e        operator_o,
    output logic [31:0]    operand_a_o,
    output logic [31:0]    operand_b_o,
    output logic           instr_first_cycle_o,
    output logic [31:0]    imd_val_q_o [2],
    input  logic [31:0]    alu_imd_val_d_i [2],
    input  logic [1:0]     alu_imd_val_we_i,
    input  logic [31:0]    alu_result_i,
    output logic           result_valid_o,
    output logic [31:0]    result_o,
    input  logic           result_ready_i,
    output logic           busy_o
);

    typedef enum logic [1:0] {StIdle, StExec1, StExec2, StResp} state_e;

    state_e      r_state;
    state_e      w_state_d;
    alu_op_e     r_operator;
    logic [31:0] r_operand_a;
    logic [31:0] r_operand_b;
    logic [31:0] r_result;
    logic [31:0] r_imd_val [2];

    logic w_accept;
    logic w_multicycle;
    logic w_exec;
    logic w_done;

    // Two-cycle ops only exist when bitmanip support is built in.
    assign w_multicycle = (RV32B != RV32BNone) &&
                          (r_operator inside {ALU_FSL, ALU_FSR, ALU_ROL, ALU_ROR});

    assign req_ready_o = (r_state == StIdle) && !flush_i;
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_exec      = (r_state == StExec1) || (r_state == StExec2);
    assign w_done      = ((r_state == StExec1) && !w_multicycle) || (r_state == StExec2);

    always_comb begin
        w_state_d = r_state;
        if (flush_i) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle:  if (w_accept) w_state_d = StExec1;
                StExec1: w_state_d = w_multicycle ? StExec2 : StResp;
                StExec2: w_state_d = StResp;
                StResp:  if (result_ready_i) w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_operator   <= ALU_ADD;
            r_operand_a  <= '0;
            r_operand_b  <= '0;
            r_result     <= '0;
            r_imd_val[0] <= '0;
            r_imd_val[1] <= '0;
        end else begin
            r_state <= w_state_d;
            if (flush_i) begin
                r_imd_val[0] <= '0;
                r_imd_val[1] <= '0;
            end else if (w_accept) begin
                r_operator   <= operator_i;
                r_operand_a  <= operand_a_i;
                r_operand_b  <= operand_b_i;
                r_imd_val[0] <= '0;
                r_imd_val[1] <= '0;
            end else if (w_exec) begin
                for (int i = 0; i < 2; i++) begin
                    if (alu_imd_val_we_i[i]) r_imd_val[i] <= alu_imd_val_d_i[i];
                end
                if (w_done) r_result <= alu_result_i;
            end
        end
    end

    assign operator_o          = r_operator;
    assign operand_a_o         = r_operand_a;
    assign operand_b_o         = r_operand_b;
    assign instr_first_cycle_o = (r_state == StExec1);
    assign imd_val_q_o         = r_imd_val;
    assign result_valid_o      = (r_state == StResp);
    assign result_o            = r_result;
    assign busy_o              = (r_state != StIdle);

endmodule
